// File: rtl/delta_sigma_pkg.sv
// Shared constants and types for the delta-sigma PW modulator datapath.
package delta_sigma_pkg;

    localparam int SAMPLE_BITS = 16;

    // Mid-scale sample, 1 << (FRAC_BITS-1)
    localparam logic [SAMPLE_BITS-1:0] RESET_SAMPLE = 16'h2000;

    // Host strobe synchronizer depth and its idle (strobe high) value
    localparam int SYNC_STAGES = 3;
    localparam logic [SYNC_STAGES-1:0] SYNC_RESET = '1;

    typedef logic [SAMPLE_BITS-1:0] sample_t;

endpackage

// File: rtl/ds_sample_fifo.sv
// Small sample FIFO: extended pointers, storage, level and full/empty.
// push/pop are single-cycle requests. A push is taken when not full, or when
// full and a pop is taken in the same cycle. A pop is taken only when the FIFO
// is non-empty; there is no bypass from push to pop.
module ds_sample_fifo
    import delta_sigma_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  sample_t              wdata,
    output sample_t              head,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   level
);

    logic [LOG_DEPTH:0] wptr;
    logic [LOG_DEPTH:0] rptr;
    sample_t            mem [DEPTH];
    logic               do_push;
    logic               do_pop;

    // Status derived from the pointer pair; MSB is the wrap bit
    always_comb begin
        level   = wptr - rptr;
        empty   = (wptr == rptr);
        full    = (wptr[LOG_DEPTH] != rptr[LOG_DEPTH]) &&
                  (wptr[LOG_DEPTH-1:0] == rptr[LOG_DEPTH-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rptr[LOG_DEPTH-1:0]];
    end

    // Pointer update; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[LOG_DEPTH-1:0]] <= wdata;
    end

endmodule

// File: rtl/ds_sample_feeder.sv
// Sample feeder: assembles 16-bit samples from the host byte bus, buffers them
// and releases one to the modulator every (divider+1) completed pulses.
module ds_sample_feeder
    import delta_sigma_pkg::*;
#(
    parameter int                     DEPTH        = 4,
    parameter int                     LOG_DEPTH    = 2,
    parameter int                     DIV_BITS     = 8,
    parameter logic [SAMPLE_BITS-1:0] RESET_SAMPLE = delta_sigma_pkg::RESET_SAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data_in,
    input  logic                 data_part_in,
    input  logic                 push_en,
    input  logic [DIV_BITS-1:0]  divider,
    input  logic                 pulse_done,
    input  logic                 clear_flags,
    output logic [15:0]          sample_out,
    output logic                 sample_valid,
    output logic [LOG_DEPTH:0]   fifo_level,
    output logic                 underrun,
    output logic                 overflow
);

    logic [SYNC_STAGES-1:0] sreg;
    logic [7:0]             data_low;
    logic [DIV_BITS-1:0]    pace_cnt;
    logic                   dp;
    logic                   last;
    logic                   rise;
    logic                   fall;
    logic                   push_req;
    logic                   pop_req;
    sample_t                head;
    logic                   full;
    logic                   empty;

    // Edge detection on the synchronized strobe and pop timing from the pacer
    always_comb begin
        dp       = sreg[1];
        last     = sreg[0];
        rise     = dp && !last;
        fall     = !dp && last;
        push_req = rise && push_en;
        pop_req  = pulse_done && (pace_cnt == '0);
    end

    // Strobe synchronizer, new value shifted in at the MSB
    always_ff @(posedge clk) begin
        if (reset) sreg <= SYNC_RESET;
        else       sreg <= {data_part_in, sreg[SYNC_STAGES-1:1]};
    end

    // Low byte latched on the falling strobe edge; deliberately not reset
    always_ff @(posedge clk) begin
        if (fall) data_low <= data_in;
    end

    ds_sample_fifo #(
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop_req),
        .wdata ({data_in, data_low}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Pace counter: divider is only sampled at reload
    always_ff @(posedge clk) begin
        if (reset) begin
            pace_cnt <= '0;
        end else if (pulse_done) begin
            if (pace_cnt == '0) pace_cnt <= divider;
            else                pace_cnt <= pace_cnt - DIV_BITS'(1);
        end
    end

    // Output sample register, updated one cycle after the popping pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out   <= RESET_SAMPLE;
            sample_valid <= 1'b0;
        end else if (pop_req && !empty) begin
            sample_out   <= head;
            sample_valid <= 1'b1;
        end
    end

    // Sticky flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (clear_flags) begin
                underrun <= 1'b0;
                overflow <= 1'b0;
            end
            if (pop_req && empty && sample_valid) underrun <= 1'b1;
            if (push_req && full && !pop_req)     overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ds_sample_feeder.sv
// Directed bench for ds_sample_feeder with an expected-sample queue.
module tb_ds_sample_feeder;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic        data_part_in;
    logic        push_en;
    logic [7:0]  divider;
    logic        pulse_done;
    logic        clear_flags;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_out;

    ds_sample_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_part_in (data_part_in),
        .push_en      (push_en),
        .divider      (divider),
        .pulse_done   (pulse_done),
        .clear_flags  (clear_flags),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Host write: low byte on strobe low, high byte on strobe high.
    // with_pop raises pulse_done in the cycle the rising edge is acted on.
    task automatic push_word(input logic [15:0] w, input bit en, input bit with_pop);
        @(negedge clk);
        data_in      = w[7:0];
        data_part_in = 1'b0;
        repeat (4) @(negedge clk);
        data_in      = w[15:8];
        push_en      = en;
        data_part_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (with_pop) pulse_done = 1'b1;
        @(negedge clk);
        pulse_done = 1'b0;
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic pulse();
        @(negedge clk);
        pulse_done = 1'b1;
        @(negedge clk);
        pulse_done = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        data_in      = 8'h00;
        data_part_in = 1'b1;
        push_en      = 1'b0;
        divider      = 8'd0;
        pulse_done   = 1'b0;
        clear_flags  = 1'b0;
        do_reset();

        // Reset state and pulses with empty FIFO before any sample
        @(negedge clk);
        check("rst_sample", sample_out, 16'h2000);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_flags", {underrun, overflow}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            repeat (8) @(negedge clk);
            pulse();
        end
        check("empty_sample", sample_out, 16'h2000);
        check("empty_valid", sample_valid, 1'b0);
        check("empty_underrun", underrun, 1'b0);

        // Rising edge without push_en is ignored
        push_word(16'hBEEF, 1'b0, 1'b0);
        check("noen_level", fifo_level, 3'd0);

        // Single sample, divider 0
        push_word(16'h1234, 1'b1, 1'b0);
        check("one_level", fifo_level, 3'd1);
        divider = 8'd0;
        pulse();
        check("one_level_after", fifo_level, 3'd0);
        check("one_sample", sample_out, 16'h1234);
        check("one_valid", sample_valid, 1'b1);

        // divider 2: pops on pulses 1, 4, 7, 10; underrun on pulse 13
        divider = 8'd2;
        for (int i = 1; i <= 4; i++) begin
            push_word(16'(i), 1'b1, 1'b0);
            exp_q.push_back(16'(i));
        end
        check("div_level", fifo_level, 3'd4);
        exp_out = 16'h1234;
        for (int k = 1; k <= 12; k++) begin
            pulse();
            if (k == 1 || k == 4 || k == 7 || k == 10) exp_out = exp_q.pop_front();
            check($sformatf("div_sample_p%0d", k), sample_out, exp_out);
            check($sformatf("div_underrun_p%0d", k), underrun, 1'b0);
        end
        pulse();
        check("div_underrun_p13", underrun, 1'b1);
        check("div_hold_p13", sample_out, 16'h0004);

        // Overflow: five pushes into a four-entry FIFO
        do_reset();
        divider = 8'd0;
        for (int i = 1; i <= 5; i++) begin
            push_word(16'hA000 + 16'(i), 1'b1, 1'b0);
            if (i <= 4) exp_q.push_back(16'hA000 + 16'(i));
        end
        check("ovf_level", fifo_level, 3'd4);
        check("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pulse();
            check($sformatf("ovf_pop%0d", i), sample_out, exp_q.pop_front());
        end
        check("ovf_drained", fifo_level, 3'd0);
        pulse();
        check("ovf_word5_lost", sample_out, 16'hA004);
        check("ovf_underrun", underrun, 1'b1);

        // Push and pop in the same cycle while full
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("clr_flags", {underrun, overflow}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            push_word(16'hC0D0 + 16'(i), 1'b1, 1'b0);
            exp_q.push_back(16'hC0D0 + 16'(i));
        end
        check("full_level", fifo_level, 3'd4);
        push_word(16'h5A5A, 1'b1, 1'b1);
        exp_q.push_back(16'h5A5A);
        check("pp_level", fifo_level, 3'd4);
        check("pp_overflow", overflow, 1'b0);
        check("pp_sample", sample_out, exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            pulse();
            check($sformatf("pp_pop%0d", i), sample_out, exp_q.pop_front());
        end
        check("pp_drained", fifo_level, 3'd0);

        // Clear in the same cycle as an underrun: set wins
        @(negedge clk);
        clear_flags = 1'b1;
        pulse_done  = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        pulse_done  = 1'b0;
        check("clr_vs_set", underrun, 1'b1);
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("clr_alone", underrun, 1'b0);

        // Reset mid-stream
        push_word(16'h7777, 1'b1, 1'b0);
        push_word(16'h8888, 1'b1, 1'b0);
        check("mid_level", fifo_level, 3'd2);
        do_reset();
        @(negedge clk);
        check("mid_rst_level", fifo_level, 3'd0);
        check("mid_rst_sample", sample_out, 16'h2000);
        check("mid_rst_valid", sample_valid, 1'b0);
        pulse();
        check("mid_rst_nopop", sample_out, 16'h2000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
